alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning operand and result width.
REQ-002 The block SHALL have parameter OPW, default 4, meaning ALU opcode width, matching the ALUOP_* encodings.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0_valid, req1_valid  input  1 each  request pending from requester 0/1.
REQ-006 The block SHALL have ports req0_ready, req1_ready  output  1 each  request accepted this cycle.
REQ-007 The block SHALL have ports req0_aluop, req1_aluop  input  OPW each  requested operation.
REQ-008 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W each  operands.
REQ-009 The block SHALL have ports alu_op  output  OPW, and alu_a, alu_b  output  W each  registered drive to the shared combinational ALU.
REQ-010 The block SHALL have port alu_out  input  W  result from the shared ALU.
REQ-011 The block SHALL have ports rsp_valid  output  1, rsp_id  output  1, and rsp_data  output  W, meaning result valid, originating requester, and result value.
REQ-012 The block SHALL have port rsp_ready  input  1  consumer accepts the result.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-014 In IDLE with any reqN_valid, the block SHALL grant exactly one requester and assert that reqN_ready combinationally in the same cycle; otherwise ready SHALL be 0.
REQ-015 Transfer SHALL occur on reqN_valid && reqN_ready; on transfer, alu_op/alu_a/alu_b SHALL latch the granted payload, rsp_id SHALL latch the grant, and the FSM SHALL move IDLE->EXEC.
REQ-016 In EXEC, rsp_data SHALL register alu_out and the FSM SHALL move to RESP.
REQ-017 In RESP, rsp_valid SHALL be 1; on rsp_ready the FSM SHALL return to IDLE, otherwise hold RESP with rsp_data and rsp_id stable.
REQ-018 Latency SHALL be: transfer in cycle N -> rsp_valid first high in cycle N+2; maximum throughput SHALL be one operation per 3 cycles.
REQ-019 Round-robin: on a tie, the requester not granted last SHALL win; with a single valid, that requester SHALL win regardless of history.
REQ-020 The last-grant pointer SHALL update only on transfer.
REQ-021 Both readys SHALL be 0 in EXEC and RESP; requesters hold valid and payload stable until ready.
REQ-022 rsp_data SHALL be the W-bit ALU result, unmodified (wrap-around is the ALU's, e.g. 255+1 -> 0).
REQ-023 alu_op/alu_a/alu_b SHALL hold their values outside transfer.

Reset
REQ-024 rst_n low SHALL, asynchronously and from any state, force IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, alu_op=0, alu_a=0, alu_b=0, and last-grant pointer=1 so requester 0 wins the first tie.
REQ-025 Any in-flight operation SHALL be discarded on reset with no response produced; the first transfer is possible in the first cycle after rst_n deasserts.

Configuration
REQ-026 With macro ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties and the pointer SHALL be unused; without it, the round-robin of REQ-019 SHALL apply.

Verification
REQ-027 req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready in cycle N, rsp_valid/rsp_id=0/rsp_data=12 in cycle N+2, IDLE in N+3.
REQ-028 Both valid after reset (req0 ADD 1+1, req1 SUB 7-5), rsp_ready=1 -> req0 served first (data 2, id 0), then req1 (data 2, id 1).
REQ-029 Both continuously valid for 4 ops -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-030 rsp_ready held 0 for 3 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable, both readys 0, and completion on the 4th cycle when rsp_ready=1.
REQ-031 rst_n pulsed low in EXEC -> outputs zero immediately, no rsp_valid afterwards, and a tie afterwards grants requester 0.
REQ-032 req1 ADD 255+1 alone -> rsp_data=0, rsp_id=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of one shared combinational ALU: IDLE grants a requester, EXEC captures alu_out, RESP holds the result until the consumer takes it.
// Defining ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie, and the last-grant pointer is then removed.

package alu_arbiter_pkg;
  // Opcodes understood by the shared ALU; the arbiter passes them through unchanged.
  localparam logic [3:0] ALUOP_ADD    = 4'd0;
  localparam logic [3:0] ALUOP_SUB    = 4'd1;
  localparam logic [3:0] ALUOP_AND    = 4'd2;
  localparam logic [3:0] ALUOP_OR     = 4'd3;
  localparam logic [3:0] ALUOP_XOR    = 4'd4;
  localparam logic [3:0] ALUOP_SHL    = 4'd5;
  localparam logic [3:0] ALUOP_SHR    = 4'd6;
  localparam logic [3:0] ALUOP_PASS_A = 4'd7;
endpackage

module alu_arbiter #(
  parameter int W   = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_aluop,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_aluop,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,

  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_out,

  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_data,
  input  logic           rsp_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   data_q, data_d;
  logic           id_q, id_d;
  logic           any_valid;
  logic           grant;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic           last_q, last_d;
`endif

  // Requester that would be granted if the FSM is idle; 1 means requester 1.
  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant = ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else begin
      grant = ~req0_valid;
    end
`endif
  end

  // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    id_d       = id_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req0_ready = ~grant;
          req1_ready = grant;
          op_d       = grant ? req1_aluop : req0_aluop;
          a_d        = grant ? req1_a     : req0_a;
          b_d        = grant ? req1_b     : req0_b;
          id_d       = grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d     = grant;
`endif
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = alu_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      id_q    <= id_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;

  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  a_rsp_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written corner sequences, and random traffic against a transaction-level model.
// Models the shared ALU itself, and follows ALU_ARB_FIXED_PRIO_EN the same way the design does.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W   = 8;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           v0 = 1'b0, v1 = 1'b0;
  logic           r0, r1;
  logic [OPW-1:0] op0 = '0, op1 = '0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic           rsp_valid, rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rr = 1'b0;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_aluop(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_aluop(op1), .req1_a(a1), .req1_b(b1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rr)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      ALUOP_ADD:    return a + b;
      ALUOP_SUB:    return a - b;
      ALUOP_AND:    return a & b;
      ALUOP_OR:     return a | b;
      ALUOP_XOR:    return a ^ b;
      ALUOP_SHL:    return a << b[2:0];
      ALUOP_SHR:    return a >> b[2:0];
      ALUOP_PASS_A: return a;
      default:      return '0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit fixed_prio();
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_inputs();
    v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
    op0 = '0; a0 = '0; b0 = '0; op1 = '0; a1 = '0; b1 = '0;
  endtask

  // Leaves the caller at a negedge with rst_n just released: the first usable cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #2;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data",  32'(rsp_data),  32'd0);
    check("rst_aluop", 32'(alu_op),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic           v0;
    logic [OPW-1:0] op0;
    logic [W-1:0]   a0, b0;
    logic           v1;
    logic [OPW-1:0] op1;
    logic [W-1:0]   a1, b1;
    logic           rr;
    logic           e_r0, e_r1, e_v, e_id;
    logic [W-1:0]   e_data;
  } vec_t;

  function automatic vec_t mk(input logic v0_, input logic [OPW-1:0] op0_, input logic [W-1:0] a0_, input logic [W-1:0] b0_,
                              input logic v1_, input logic [OPW-1:0] op1_, input logic [W-1:0] a1_, input logic [W-1:0] b1_,
                              input logic rr_, input logic e_r0_, input logic e_r1_, input logic e_v_, input logic e_id_,
                              input logic [W-1:0] e_data_);
    vec_t v;
    v.v0 = v0_; v.op0 = op0_; v.a0 = a0_; v.b0 = b0_;
    v.v1 = v1_; v.op1 = op1_; v.a1 = a1_; v.b1 = b1_;
    v.rr = rr_; v.e_r0 = e_r0_; v.e_r1 = e_r1_; v.e_v = e_v_; v.e_id = e_id_; v.e_data = e_data_;
    return v;
  endfunction

  vec_t tbl[13];

  // Transaction-level reference state for the random phase.
  bit             m_busy;
  int             m_t;
  bit             m_id;
  bit             m_last;
  logic [OPW-1:0] m_op;
  logic [W-1:0]   m_a, m_b, m_data;

  initial begin
    bit       g;
    bit       e_r0, e_r1, e_v;
    int       grants[$];
    int       budget;

    // ---------------- directed vector table ----------------
    tbl[0]  = mk(1, ALUOP_ADD, 8'd1, 8'd1,   1, ALUOP_SUB, 8'd7, 8'd5, 1, 1, 0, 0, 0, 8'd0);
    tbl[1]  = mk(0, 4'd0, 8'd0, 8'd0,        1, ALUOP_SUB, 8'd7, 8'd5, 1, 0, 0, 0, 0, 8'd0);
    tbl[2]  = mk(0, 4'd0, 8'd0, 8'd0,        1, ALUOP_SUB, 8'd7, 8'd5, 1, 0, 0, 1, 0, 8'd2);
    tbl[3]  = mk(0, 4'd0, 8'd0, 8'd0,        1, ALUOP_SUB, 8'd7, 8'd5, 1, 0, 1, 0, 0, 8'd0);
    tbl[4]  = mk(0, 4'd0, 8'd0, 8'd0,        0, 4'd0, 8'd0, 8'd0,      1, 0, 0, 0, 0, 8'd0);
    tbl[5]  = mk(0, 4'd0, 8'd0, 8'd0,        0, 4'd0, 8'd0, 8'd0,      1, 0, 0, 1, 1, 8'd2);
    tbl[6]  = mk(1, ALUOP_ADD, 8'd5, 8'd7,   0, 4'd0, 8'd0, 8'd0,      1, 1, 0, 0, 0, 8'd0);
    tbl[7]  = mk(0, 4'd0, 8'd0, 8'd0,        0, 4'd0, 8'd0, 8'd0,      1, 0, 0, 0, 0, 8'd0);
    tbl[8]  = mk(0, 4'd0, 8'd0, 8'd0,        0, 4'd0, 8'd0, 8'd0,      1, 0, 0, 1, 0, 8'd12);
    tbl[9]  = mk(0, 4'd0, 8'd0, 8'd0,        1, ALUOP_ADD, 8'd255, 8'd1, 1, 0, 1, 0, 0, 8'd0);
    tbl[10] = mk(0, 4'd0, 8'd0, 8'd0,        0, 4'd0, 8'd0, 8'd0,      1, 0, 0, 0, 0, 8'd0);
    tbl[11] = mk(0, 4'd0, 8'd0, 8'd0,        0, 4'd0, 8'd0, 8'd0,      1, 0, 0, 1, 1, 8'd0);
    tbl[12] = mk(0, 4'd0, 8'd0, 8'd0,        0, 4'd0, 8'd0, 8'd0,      1, 0, 0, 0, 0, 8'd0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      v0 = tbl[i].v0; op0 = tbl[i].op0; a0 = tbl[i].a0; b0 = tbl[i].b0;
      v1 = tbl[i].v1; op1 = tbl[i].op1; a1 = tbl[i].a1; b1 = tbl[i].b1;
      rr = tbl[i].rr;
      #2;
      check($sformatf("tbl%0d_r0", i), 32'(r0), 32'(tbl[i].e_r0));
      check($sformatf("tbl%0d_r1", i), 32'(r1), 32'(tbl[i].e_r1));
      check($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].e_v));
      if (tbl[i].e_v) begin
        check($sformatf("tbl%0d_id", i),   32'(rsp_id),   32'(tbl[i].e_id));
        check($sformatf("tbl%0d_data", i), 32'(rsp_data), 32'(tbl[i].e_data));
      end
      @(negedge clk);
    end

    // ---------------- continuous contention: grant order ----------------
    do_reset();
    v0 = 1'b1; op0 = ALUOP_ADD; a0 = 8'd10; b0 = 8'd1;
    v1 = 1'b1; op1 = ALUOP_SUB; a1 = 8'd20; b1 = 8'd1;
    rr = 1'b1;
    budget = 0;
    while (grants.size() < 4 && budget < 40) begin
      #2;
      check("contend_excl", 32'(r0 & r1), 32'd0);
      if (r0) grants.push_back(0);
      if (r1) grants.push_back(1);
      @(negedge clk);
      a0 = a0 + 8'd1;
      a1 = a1 + 8'd1;
      budget++;
    end
    check("contend_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < grants.size(); k++) begin
      check($sformatf("contend_grant%0d", k), 32'(grants[k]), fixed_prio() ? 32'd0 : 32'(k % 2));
    end
    clear_inputs();

    // ---------------- back-pressure in RESP ----------------
    do_reset();
    v0 = 1'b1; op0 = ALUOP_XOR; a0 = 8'hA5; b0 = 8'h3C;
    #2;
    check("stall_accept", 32'(r0), 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b1; op1 = ALUOP_SUB; a1 = 8'd9; b1 = 8'd4;
    #2;
    check("stall_exec_r1", 32'(r1), 32'd0);
    @(negedge clk);
    v0 = 1'b1; op0 = ALUOP_OR; a0 = 8'h0F; b0 = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d_data", k),  32'(rsp_data),  32'h99);
      check($sformatf("stall%0d_id", k),    32'(rsp_id),    32'd0);
      check($sformatf("stall%0d_rdy", k),   32'({r0, r1}),  32'd0);
      @(negedge clk);
    end
    rr = 1'b1;
    #2;
    check("stall_done_valid", 32'(rsp_valid), 32'd1);
    check("stall_done_data",  32'(rsp_data),  32'h99);
    @(negedge clk);
    #2;
    check("stall_next_valid", 32'(rsp_valid), 32'd0);
    check("stall_next_r0", 32'(r0), fixed_prio() ? 32'd1 : 32'd0);
    check("stall_next_r1", 32'(r1), fixed_prio() ? 32'd0 : 32'd1);
    @(negedge clk);
    clear_inputs();

    // ---------------- reset while an operation is in flight ----------------
    do_reset();
    v0 = 1'b1; op0 = ALUOP_ADD; a0 = 8'd3; b0 = 8'd4;
    rr = 1'b1;
    #2;
    check("abort_accept", 32'(r0), 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    #2;
    check("abort_exec_a", 32'(alu_a), 32'd3);
    rst_n = 1'b0;
    #1;
    check("abort_op",    32'(alu_op),    32'd0);
    check("abort_a",     32'(alu_a),     32'd0);
    check("abort_b",     32'(alu_b),     32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_id",    32'(rsp_id),    32'd0);
    check("abort_data",  32'(rsp_data),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("abort_quiet%0d", k), 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    v0 = 1'b1; op0 = ALUOP_AND; a0 = 8'hF0; b0 = 8'h3C;
    v1 = 1'b1; op1 = ALUOP_ADD; a1 = 8'd1;  b1 = 8'd2;
    #2;
    check("abort_tie_r0", 32'(r0), 32'd1);
    check("abort_tie_r1", 32'(r1), 32'd0);
    @(negedge clk);
    clear_inputs();

    // ---------------- random traffic against the transaction model ----------------
    do_reset();
    m_busy = 1'b0; m_t = 0; m_id = 1'b0; m_last = 1'b1;
    m_op = '0; m_a = '0; m_b = '0; m_data = '0;
    for (int c = 0; c < 800; c++) begin
      if (!v0 && $urandom_range(0, 1) == 1) begin
        v0 = 1'b1; op0 = OPW'($urandom_range(0, 15)); a0 = W'($urandom); b0 = W'($urandom);
      end
      if (!v1 && $urandom_range(0, 1) == 1) begin
        v1 = 1'b1; op1 = OPW'($urandom_range(0, 15)); a1 = W'($urandom); b1 = W'($urandom);
      end
      rr = ($urandom_range(0, 3) != 0);
      #2;
      e_r0 = 1'b0; e_r1 = 1'b0; g = 1'b0;
      if (!m_busy && (v0 || v1)) begin
        if (v0 && v1) g = fixed_prio() ? 1'b0 : ~m_last;
        else          g = !v0;
        e_r0 = !g;
        e_r1 = g;
      end
      e_v = m_busy && (c >= m_t + 2);
      check("rnd_r0", 32'(r0), 32'(e_r0));
      check("rnd_r1", 32'(r1), 32'(e_r1));
      check("rnd_valid", 32'(rsp_valid), 32'(e_v));
      if (e_v) begin
        check("rnd_id",   32'(rsp_id),   32'(m_id));
        check("rnd_data", 32'(rsp_data), 32'(m_data));
      end
      if (m_busy && c == m_t + 1) begin
        check("rnd_alu_op", 32'(alu_op), 32'(m_op));
        check("rnd_alu_a",  32'(alu_a),  32'(m_a));
        check("rnd_alu_b",  32'(alu_b),  32'(m_b));
      end
      if (e_v && rr) m_busy = 1'b0;
      if (e_r0 || e_r1) begin
        m_busy = 1'b1;
        m_t    = c;
        m_id   = g;
        m_last = g;
        m_op   = g ? op1 : op0;
        m_a    = g ? a1 : a0;
        m_b    = g ? b1 : b0;
        m_data = alu_fn(m_op, m_a, m_b);
      end
      @(negedge clk);
      if (e_r0) v0 = 1'b0;
      if (e_r1) v1 = 1'b0;
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
